// File: rtl/alu_result_stage.sv
// ---------------------------------------------------------------------------
// alu_result_stage
//   Two-entry in-order buffer that decouples the ALU result {R,O,N,Z} from a
//   downstream consumer using a valid/ready handshake on both sides.
//
//   The oldest record lives in the head register, which drives out_* directly.
//   The second record waits in the tail register. in_ready and out_valid are
//   flops too, so neither has a combinational path from any input.
//
// Parameters
//   n            datapath width of the ALU result
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   in_valid     upstream record valid
//   in_ready     buffer can take a record (occupancy < 2)
//   in_r/o/n/z   ALU result and its overflow/negative/zero flags
//   out_valid    buffer holds at least one record
//   out_ready    downstream takes the presented record
//   out_r/o/n/z  oldest buffered record, flags stored verbatim
//   clr_sticky   clear sticky overflow state     (ALU_RESULT_STICKY_EN only)
//   sticky_o     an overflowing result was pushed (ALU_RESULT_STICKY_EN only)
//   ovf_count    saturating count of overflow pushes (ALU_RESULT_STICKY_EN only)
//
// Configuration macro: ALU_RESULT_STICKY_EN
// ---------------------------------------------------------------------------
module alu_result_stage #(
    parameter int n = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [n-1:0] in_r,
    input  logic         in_o,
    input  logic         in_n,
    input  logic         in_z,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [n-1:0] out_r,
    output logic         out_o,
    output logic         out_n,
    output logic         out_z
`ifdef ALU_RESULT_STICKY_EN
    ,
    input  logic         clr_sticky,
    output logic         sticky_o,
    output logic [7:0]   ovf_count
`endif
);

    localparam int RW = n + 3;

    logic [RW-1:0] head_q, head_d;
    logic [RW-1:0] tail_q, tail_d;
    logic [1:0]    count_q, count_d;
    logic          in_ready_q, in_ready_d;
    logic          out_valid_q, out_valid_d;
    logic          push_s, pop_s;
    logic [RW-1:0] in_rec_s;

    assign in_rec_s = {in_r, in_o, in_n, in_z};
    assign push_s   = in_valid & in_ready_q;
    assign pop_s    = out_valid_q & out_ready;

    // Next-state of the head/tail registers and occupancy.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        case (count_q)
            2'd0: begin
                if (push_s) begin
                    head_d  = in_rec_s;
                    count_d = 2'd1;
                end else begin
                    count_d = 2'd0;
                end
            end
            2'd1: begin
                case ({push_s, pop_s})
                    2'b10: begin
                        tail_d  = in_rec_s;
                        count_d = 2'd2;
                    end
                    2'b01: begin
                        count_d = 2'd0;
                    end
                    // Head is consumed and replaced in the same edge.
                    2'b11: begin
                        head_d  = in_rec_s;
                        count_d = 2'd1;
                    end
                    default: begin
                        count_d = 2'd1;
                    end
                endcase
            end
            2'd2: begin
                // Full: in_ready is low so only a pop can happen.
                if (pop_s) begin
                    head_d  = tail_q;
                    count_d = 2'd1;
                end else begin
                    count_d = 2'd2;
                end
            end
            default: begin
                count_d = 2'd0;
            end
        endcase
        in_ready_d  = (count_d != 2'd2);
        out_valid_d = (count_d != 2'd0);
    end

    // Buffer state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q      <= {RW{1'b0}};
            tail_q      <= {RW{1'b0}};
            count_q     <= 2'd0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_r     = head_q[RW-1:3];
    assign out_o     = head_q[2];
    assign out_n     = head_q[1];
    assign out_z     = head_q[0];

`ifdef ALU_RESULT_STICKY_EN
    logic       sticky_q, sticky_d;
    logic [7:0] ovf_count_q, ovf_count_d;
    logic       ovf_push_s;

    assign ovf_push_s = push_s & in_o;

    // Sticky flag and saturating overflow counter; a same-cycle overflow push beats clear.
    always_comb begin
        if (ovf_push_s) begin
            sticky_d = 1'b1;
        end else if (clr_sticky) begin
            sticky_d = 1'b0;
        end else begin
            sticky_d = sticky_q;
        end

        if (clr_sticky) begin
            ovf_count_d = ovf_push_s ? 8'd1 : 8'd0;
        end else if (ovf_push_s && (ovf_count_q != 8'd255)) begin
            ovf_count_d = ovf_count_q + 8'd1;
        end else begin
            ovf_count_d = ovf_count_q;
        end
    end

    // Sticky overflow registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sticky_q    <= 1'b0;
            ovf_count_q <= 8'd0;
        end else begin
            sticky_q    <= sticky_d;
            ovf_count_q <= ovf_count_d;
        end
    end

    assign sticky_o  = sticky_q;
    assign ovf_count = ovf_count_q;
`endif

endmodule

// File: doc/alu_result_stage.md
ALU_RESULT_STAGE -- requirements
Module: alu_result_stage

Interface
REQ-001 SHALL have parameter: n, default 32, datapath width in bits (matches the ALU result width).
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports: in_valid input 1, in_ready output 1 (upstream handshake).
REQ-005 SHALL have ports: in_r input n, in_o, in_n, in_z input 1 each (ALU result R and flags O, N, Z).
REQ-006 SHALL have ports: out_valid output 1, out_ready input 1 (downstream handshake).
REQ-007 SHALL have ports: out_r output n, out_o, out_n, out_z output 1 each (buffered result and flags).
REQ-008 SHALL have ports: clr_sticky input 1, sticky_o output 1, ovf_count output 8 (present only per REQ-024).

Function
REQ-009 SHALL implement a 2-entry in-order FIFO of {R,O,N,Z} records.
REQ-010 SHALL perform a push on a clk edge when in_valid=1 and in_ready=1.
REQ-011 SHALL perform a pop on a clk edge when out_valid=1 and out_ready=1.
REQ-012 SHALL drive in_ready=1 iff occupancy<2; in_ready SHALL depend only on registered state, with no combinational path from out_ready or in_valid.
REQ-013 SHALL drive out_valid=1 iff occupancy>0; out_* SHALL present the oldest entry.
REQ-014 SHALL provide 1-cycle latency: a record pushed into an empty FIFO appears on out_* with out_valid=1 in the following cycle.
REQ-015 SHALL hold out_* and out_valid stable while out_valid=1 and out_ready=0.
REQ-016 SHALL, with occupancy 1 and simultaneous push and pop, leave occupancy at 1 and present the new record next cycle.
REQ-017 SHALL, at occupancy 2, accept no push (in_ready=0); a pop SHALL bring occupancy to 1 and raise in_ready in the next cycle.
REQ-018 SHALL, at occupancy 0, ignore out_ready.
REQ-019 SHALL store flags verbatim, with no recomputation; out_z SHALL equal the stored in_z even if out_r disagrees.

Reset
REQ-020 SHALL, on rst_n=0, asynchronously clear occupancy and pointers to 0, giving out_valid=0 and in_ready=1 once rst_n is released.
REQ-021 SHALL reset out_r=0 and out_o=out_n=out_z=0; sticky_o=0 and ovf_count=0 when present.
REQ-022 SHALL discard all buffered records when reset is asserted mid-transfer; the first post-reset push SHALL be the first record output.
REQ-023 SHALL accept no push or pop in the cycle in which rst_n=0.

Configuration
REQ-024 SHALL, when macro ALU_RESULT_STICKY_EN is defined, include the sticky overflow logic per REQ-025 to REQ-027; when the macro is undefined, clr_sticky, sticky_o and ovf_count SHALL be absent and the FIFO behaviour SHALL be unchanged.
REQ-025 SHALL set sticky_o to 1 on any push with in_o=1; clr_sticky=1 SHALL clear it; if clear and set occur in the same cycle, the set SHALL win.
REQ-026 SHALL increment ovf_count by 1 on each push with in_o=1, saturating at 255.
REQ-027 SHALL clear ovf_count to 0 when clr_sticky=1; if clear and increment occur in the same cycle, ovf_count SHALL become 1.

Verification
REQ-028 SHALL cover: n=32; push R=0x0000_0005, Z=0 into an empty FIFO with out_ready=1 -> out_valid=1 with out_r=0x5 next cycle, then out_valid=0.
REQ-029 SHALL cover: out_ready=0; push 0xA, 0xB, 0xC on consecutive cycles -> in_ready=0 after 2 pushes, 0xC not accepted; after releasing out_ready, outputs are 0xA then 0xB.
REQ-030 SHALL cover: occupancy 1 with a simultaneous push and pop every cycle for 10 cycles -> occupancy stays 1, in-order output, in_ready held 1.
REQ-031 SHALL cover: rst_n pulsed low with 2 entries held -> out_valid=0 immediately and in_ready=1 after release; the next push of 0x7 is output first.
REQ-032 SHALL cover (ALU_RESULT_STICKY_EN): 300 pushes with in_o=1 -> ovf_count=255 and sticky_o=1; clr_sticky together with an O=1 push -> ovf_count=1 and sticky_o=1.
